// File: rtl/cpu_pkg.sv
// Shared fetch/decode types: instruction-address and instruction widths, fetch-queue entry.
package cpu_pkg;
   localparam int PC_W     = 11;
   localparam int INSTR_W  = 32;
   localparam int FQ_DEPTH = 8;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               pred;
   } fq_entry_t;

   // Decode may request 3, but at most two entries are ever presented.
   function automatic logic [1:0] clamp_pop(input logic [1:0] p);
      return (p == 2'd3) ? 2'd2 : p;
   endfunction
endpackage

// File: rtl/dual_fetch_queue_if.sv
// Fetch-side push pair, decode-side read pair and flush, bundled for the fetch queue.
interface dual_fetch_queue_if #(parameter int DEPTH = cpu_pkg::FQ_DEPTH);
   import cpu_pkg::*;
   localparam int CW = $clog2(DEPTH) + 1;

   logic                flush;
   logic [1:0]          in_valid;
   logic [PC_W-1:0]     in_pc0;
   logic [INSTR_W-1:0]  in_instr0, in_instr1;
   logic                in_pred0, in_pred1;
   logic                in_ready;
   logic [1:0]          out_valid;
   logic [PC_W-1:0]     out_pc0, out_pc1;
   logic [INSTR_W-1:0]  out_instr0, out_instr1;
   logic                out_pred0, out_pred1;
   logic [1:0]          pop;
   logic [CW-1:0]       count;

   modport master (
      output flush, in_valid, in_pc0, in_instr0, in_instr1, in_pred0, in_pred1, pop,
      input  in_ready, out_valid, out_pc0, out_pc1, out_instr0, out_instr1,
             out_pred0, out_pred1, count
   );

   modport slave (
      input  flush, in_valid, in_pc0, in_instr0, in_instr1, in_pred0, in_pred1, pop,
      output in_ready, out_valid, out_pc0, out_pc1, out_instr0, out_instr1,
             out_pred0, out_pred1, count
   );
endinterface

// File: rtl/fq_storage.sv
// Entry register array with two write ports and two asynchronous read ports.
module fq_storage
   import cpu_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we0,
   input  logic [AW-1:0] waddr0,
   input  fq_entry_t     wdata0,
   input  logic          we1,
   input  logic [AW-1:0] waddr1,
   input  fq_entry_t     wdata1,
   input  logic [AW-1:0] raddr0,
   output fq_entry_t     rdata0,
   input  logic [AW-1:0] raddr1,
   output fq_entry_t     rdata1
);
   fq_entry_t mem_q [DEPTH];
   fq_entry_t mem_d [DEPTH];

   // Port 1 is applied last so it wins a same-address write.
   always_comb begin
      mem_d = mem_q;
      if (we0) mem_d[waddr0] = wdata0;
      if (we1) mem_d[waddr1] = wdata1;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata0 = mem_q[raddr0];
   assign rdata1 = mem_q[raddr1];
endmodule

// File: rtl/dual_fetch_queue.sv
// Dual-issue fetch queue: pair push, fall-through pair read, 0..2 pops per cycle, one-cycle flush.
module dual_fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   dual_fetch_queue_if.slave  q
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    n_push, n_pop, pop_c;
   logic          in_ready;
   logic          we0, we1;
   fq_entry_t     wdata0, wdata1, rdata0, rdata1;

   always_comb begin
      // Room for a full pair is judged on the current occupancy alone.
      in_ready = (count_q <= CW'(DEPTH - 2));
      n_push   = 2'd0;
      if (in_ready) begin
         if (q.in_valid == 2'b11)      n_push = 2'd2;
         else if (q.in_valid == 2'b01) n_push = 2'd1;
      end
      pop_c = clamp_pop(q.pop);
      n_pop = (count_q < CW'(pop_c)) ? count_q[1:0] : pop_c;

      we0    = !q.flush && (n_push != 2'd0);
      we1    = !q.flush && (n_push == 2'd2);
      wdata0 = '{pc: q.in_pc0,             instr: q.in_instr0, pred: q.in_pred0};
      wdata1 = '{pc: q.in_pc0 + PC_W'(1),  instr: q.in_instr1, pred: q.in_pred1};

      if (q.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + AW'(n_pop);
         wr_ptr_d = wr_ptr_q + AW'(n_push);
         count_d  = count_q + CW'(n_push) - CW'(n_pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   fq_storage #(.DEPTH(DEPTH)) u_storage (
      .clk    (clk),
      .we0    (we0),
      .waddr0 (wr_ptr_q),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (wr_ptr_q + AW'(1)),
      .wdata1 (wdata1),
      .raddr0 (rd_ptr_q),
      .rdata0 (rdata0),
      .raddr1 (rd_ptr_q + AW'(1)),
      .rdata1 (rdata1)
   );

   assign q.in_ready   = in_ready;
   assign q.out_valid  = {count_q >= CW'(2), count_q != '0};
   assign q.count      = count_q;
   assign q.out_pc0    = rdata0.pc;
   assign q.out_instr0 = rdata0.instr;
   assign q.out_pred0  = rdata0.pred;
   assign q.out_pc1    = rdata1.pc;
   assign q.out_instr1 = rdata1.instr;
   assign q.out_pred1  = rdata1.pred;
endmodule
